// File: rtl/sf_sync_fifo_if.sv
// sf_sync_fifo_if
// Streaming handshake bundle for sf_sync_fifo.
//   in_valid/in_ready/in_data    : producer -> FIFO write channel
//   out_valid/out_ready/out_data : FIFO -> consumer read channel
// Modports:
//   master : environment side (drives the write channel, consumes the read channel)
//   slave  : FIFO side
interface sf_sync_fifo_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sf_sync_fifo.sv
// sf_sync_fifo
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on
// both sides, almost-full/almost-empty flags and a synchronous flush.
// The registered output word counts toward level, so total capacity is DEPTH.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   flush        : synchronous clear, wins over push and pop in the same cycle
//   bus          : sf_sync_fifo_if.slave (write and read handshake channels)
//   level        : words held, including the output register
//   almost_full  : level >= AFULL_TH
//   almost_empty : level <= AEMPTY_TH
// Optional build macro SF_FIFO_STATS_EN adds:
//   max_level    : high-watermark of level
//   stats_clr    : synchronous clear of max_level
module sf_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    sf_sync_fifo_if.slave     bus,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty
`ifdef SF_FIFO_STATS_EN
    ,
    output logic [ADDR_W:0]   max_level,
    input  logic              stats_clr
`endif
);

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sf_sync_fifo: DEPTH must be a power of two in 4..1024");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sf_sync_fifo: AFULL_TH must not exceed DEPTH");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("sf_sync_fifo: DATA_W must be in 1..64");
    end

    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_AFULL = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   LVL_AEMPT = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
    logic [ADDR_W:0]   level_n;
    logic              out_valid_r, out_valid_n;
    logic [DATA_W-1:0] out_data_r, out_data_n;
    logic              push, pop, take, arr_empty, mem_we;

    // Ready and flags come from the registered level only, so a full FIFO
    // never accepts a word in the same cycle it pops one.
    assign bus.in_ready  = (level < LVL_DEPTH);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign almost_full   = (level >= LVL_AFULL);
    assign almost_empty  = (level <= LVL_AEMPT);

    // Next-state logic. The array holds level minus the output word; the
    // output register refills from the array head, or straight from in_data
    // when the array is empty, whenever it is empty or being popped.
    always_comb begin
        push        = bus.in_valid & bus.in_ready;
        pop         = out_valid_r & bus.out_ready;
        take        = ~out_valid_r | pop;
        arr_empty   = (level == {{ADDR_W{1'b0}}, out_valid_r});
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        level_n     = level;
        out_valid_n = out_valid_r;
        out_data_n  = out_data_r;
        mem_we      = 1'b0;

        if (flush) begin
            wr_ptr_n    = '0;
            rd_ptr_n    = '0;
            level_n     = '0;
            out_valid_n = 1'b0;
        end else begin
            if (take) begin
                if (!arr_empty) begin
                    out_data_n  = mem[rd_ptr];
                    rd_ptr_n    = rd_ptr + PTR_ONE;
                    out_valid_n = 1'b1;
                    mem_we      = push;
                end else if (push) begin
                    out_data_n  = bus.in_data;
                    out_valid_n = 1'b1;
                end else begin
                    out_valid_n = 1'b0;
                end
            end else begin
                mem_we = push;
            end

            if (mem_we) begin
                wr_ptr_n = wr_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   level_n = level + LVL_ONE;
                2'b01:   level_n = level - LVL_ONE;
                default: level_n = level;
            endcase
        end
    end

    // Control state and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            level       <= level_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
        end
    end

    // Storage array has no reset so it can map onto LSRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

`ifdef SF_FIFO_STATS_EN
    // High-watermark tracks the level being written at the same edge;
    // flush lowers level and so never touches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_level <= '0;
        end else if (stats_clr) begin
            max_level <= '0;
        end else if (level_n > max_level) begin
            max_level <= level_n;
        end
    end
`endif

endmodule

// File: tb/tb_sf_sync_fifo.sv
// tb_sf_sync_fifo
// Self-checking bench for sf_sync_fifo (DATA_W=8, DEPTH=16). A queue model
// follows the handshake rules and is compared with the DUT on every falling
// edge; directed tests add literal expectations. Honours SF_FIFO_STATS_EN.
module tb_sf_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [4:0] level;
    logic       almost_full, almost_empty;
`ifdef SF_FIFO_STATS_EN
    logic [4:0] max_level;
    logic       stats_clr = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    logic [DATA_W-1:0] modelQ [$];
    int                modelMax = 0;

    sf_sync_fifo_if #(.DATA_W(DATA_W)) bus ();

    sf_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL),
        .AEMPTY_TH(AEMPTY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`ifdef SF_FIFO_STATS_EN
        ,
        .max_level   (max_level),
        .stats_clr   (stats_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, hold them across
    // the rising edge, and return at the next falling edge.
    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d,
                                 input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, "_out_data"}, {24'd0, bus.out_data}, 32'd0);
        checkOutput({tag, "_level"}, {27'd0, level}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        checkOutput({tag, "_afull"}, {31'd0, almost_full}, 32'd0);
        checkOutput({tag, "_aempty"}, {31'd0, almost_empty}, 32'd1);
    endtask

    // Reference model: a plain queue with capacity DEPTH.
    always @(posedge clk or posedge rst) begin
        bit mPush, mPop;
        if (rst) begin
            modelQ.delete();
            modelMax = 0;
        end else begin
            mPush = bus.in_valid && (modelQ.size() < DEPTH);
            mPop  = bus.out_ready && (modelQ.size() > 0);
            if (flush) begin
                modelQ.delete();
            end else begin
                if (mPop) void'(modelQ.pop_front());
                if (mPush) modelQ.push_back(bus.in_data);
            end
`ifdef SF_FIFO_STATS_EN
            if (stats_clr) modelMax = 0;
            else if (modelQ.size() > modelMax) modelMax = modelQ.size();
`endif
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("m_out_valid", {31'd0, bus.out_valid}, (modelQ.size() > 0) ? 32'd1 : 32'd0);
            if (modelQ.size() > 0)
                checkOutput("m_out_data", {24'd0, bus.out_data}, {24'd0, modelQ[0]});
            checkOutput("m_level", {27'd0, level}, modelQ.size());
            checkOutput("m_in_ready", {31'd0, bus.in_ready}, (modelQ.size() < DEPTH) ? 32'd1 : 32'd0);
            checkOutput("m_afull", {31'd0, almost_full}, (modelQ.size() >= AFULL) ? 32'd1 : 32'd0);
            checkOutput("m_aempty", {31'd0, almost_empty}, (modelQ.size() <= AEMPTY) ? 32'd1 : 32'd0);
`ifdef SF_FIFO_STATS_EN
            checkOutput("m_max_level", {27'd0, max_level}, modelMax);
`endif
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("rst0");
        rst = 1'b0;
        checkEn = 1'b1;

        // Single push into an empty FIFO appears after one edge.
        $display("[TB] test 1: single push");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("t1_out_data", {24'd0, bus.out_data}, 32'hA5);
        checkOutput("t1_level", {27'd0, level}, 32'd1);
        checkOutput("t1_aempty", {31'd0, almost_empty}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_drained", {31'd0, bus.out_valid}, 32'd0);

        // Fill to capacity, then drain in order.
        $display("[TB] test 2: fill and drain");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 12) checkOutput("t2_afull_13", {31'd0, almost_full}, 32'd0);
            if (i == 13) checkOutput("t2_afull_14", {31'd0, almost_full}, 32'd1);
        end
        checkOutput("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("t2_level", {27'd0, level}, 32'd16);
        checkOutput("t2_afull", {31'd0, almost_full}, 32'd1);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("t2_full_hold", {27'd0, level}, 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t2_drain_data", {24'd0, bus.out_data}, i);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("t2_empty", {31'd0, bus.out_valid}, 32'd0);

        // Streaming at half-full across many pointer wraps.
        $display("[TB] test 3: streaming");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 8'(8'h28 + i), 1'b1, 1'b0);
            checkOutput("t3_level", {27'd0, level}, 32'd8);
        end
        checkOutput("t3_head", {24'd0, bus.out_data}, 32'h84);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Full with push and pop together: pop only, push lands next cycle.
        $display("[TB] test 4: full push+pop");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
        checkOutput("t4_level", {27'd0, level}, 32'd15);
        checkOutput("t4_head", {24'd0, bus.out_data}, 32'h41);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        checkOutput("t4_level_after", {27'd0, level}, 32'd16);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush beats simultaneous push and pop.
        $display("[TB] test 5: flush");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("t5_level", {27'd0, level}, 32'd0);
        checkOutput("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("t5_out_data_kept", {24'd0, bus.out_data}, 32'h50);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-burst.
        $display("[TB] test 6: async reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h6F;
        #2 rst = 1'b1;
        #1 checkReset("rst_async");
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
`ifdef SF_FIFO_STATS_EN
        checkOutput("t6_max_rst", {27'd0, max_level}, 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        checkOutput("t6_max_7", {27'd0, max_level}, 32'd7);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t6_max_after_flush", {27'd0, max_level}, 32'd7);
        stats_clr = 1'b1;
        applyStimulus(1'b1, 8'h7F, 1'b0, 1'b0);
        stats_clr = 1'b0;
        checkOutput("t6_max_clr", {27'd0, max_level}, 32'd0);
        checkOutput("t6_level_clr", {27'd0, level}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
